// File: rtl/datapath_pkg.sv
// Shared datapath constants and the fetch bundle carried between pipeline registers.
package datapath_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } fetch_bundle_t;

  typedef enum logic {
    ENTRY_BUBBLE = 1'b0,
    ENTRY_VALID  = 1'b1
  } entry_state_t;

  // Sequential PC; wraps modulo 2^32 with no carry out.
  function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall/flush handling, event counters and stall watchdog.
//   state        | meaning
//   ENTRY_BUBBLE | register holds a bubble (NOP), ValidOut = 0
//   ENTRY_VALID  | register holds a real fetched instruction, ValidOut = 1
module if_id_register
  import datapath_pkg::fetch_bundle_t;
  import datapath_pkg::entry_state_t;
  import datapath_pkg::ENTRY_BUBBLE;
  import datapath_pkg::ENTRY_VALID;
  import datapath_pkg::pc_next;
#(
  parameter logic [31:0] NOP_WORD  = datapath_pkg::NOP_WORD,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PCIn,
  input  logic [31:0]      InstrIn,
  input  logic             Stall,
  input  logic             Flush,
  output logic [31:0]      InstrOut,
  output logic [31:0]      PCOut,
  output logic [31:0]      PCPlus4Out,
  output logic             ValidOut,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             StallTimeout
);

  localparam int RUN_W   = $clog2(MAX_STALL + 2);
  localparam int RUN_SAT = MAX_STALL + 1;

  entry_state_t  state_q, state_d;
  fetch_bundle_t ent_q, ent_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ENTRY_BUBBLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush outranks Stall so a taken branch squashes even a stalled fetch.
  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    if (Flush) begin
      state_d        = ENTRY_BUBBLE;
      ent_d.instr    = NOP_WORD;
      ent_d.pc       = PCIn;
      ent_d.pc_plus4 = pc_next(PCIn);
    end else if (!Stall) begin
      state_d        = ENTRY_VALID;
      ent_d.instr    = InstrIn;
      ent_d.pc       = PCIn;
      ent_d.pc_plus4 = pc_next(PCIn);
    end
    ent_d.valid = (state_d == ENTRY_VALID);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ent_q.instr    <= NOP_WORD;
      ent_q.pc       <= '0;
      ent_q.pc_plus4 <= '0;
      ent_q.valid    <= 1'b0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign InstrOut   = ent_q.instr;
  assign PCOut      = ent_q.pc;
  assign PCPlus4Out = ent_q.pc_plus4;
  assign ValidOut   = ent_q.valid;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (Stall),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (Flush),
    .count (FlushCount)
  );

  // Run counter needs a synchronous clear on Stall=0, so it is not a sat_counter.
  logic [RUN_W-1:0] run_q;
  logic             run_hit;

  assign run_hit = Stall && (run_q == RUN_W'(MAX_STALL));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_q        <= '0;
      StallTimeout <= 1'b0;
    end else begin
      if (!Stall) begin
        run_q <= '0;
      end else if (run_q != RUN_W'(RUN_SAT)) begin
        run_q <= run_q + RUN_W'(1);
      end
      if (run_hit) begin
        StallTimeout <= 1'b1;
      end
    end
  end

endmodule
